// File: rtl/canvas_vram_arbiter.sv
`default_nettype none
// canvas_vram_arbiter: owns the canvas RAM port; display read > clear engine > draw write.
// Rev 1.0 - initial release
module canvas_vram_arbiter #(
  parameter int DW    = 15,
  parameter int H_LEN = 200,
  parameter int V_LEN = 150,
  parameter int PIX_N = H_LEN * V_LEN
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          disp_en,
  input  logic [DW-1:0] disp_addr,
  output logic [11:0]   disp_data,
  output logic          disp_valid,
  input  logic          draw_req,
  input  logic [DW-1:0] draw_addr,
  input  logic [11:0]   draw_data,
  output logic          draw_ack,
  output logic          draw_err,
  input  logic          clr_start,
  input  logic [11:0]   clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [DW-1:0] mem_addr,
  output logic [11:0]   mem_wdata,
  output logic          mem_we,
  input  logic [11:0]   mem_rdata
);

  localparam logic [DW-1:0] LAST_ADDR = DW'(PIX_N - 1);
  localparam logic [DW:0]   PIX_N_EXT = (DW+1)'(PIX_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  clr_state_t    state_q, state_d;
  logic [DW-1:0] clr_ptr_q, clr_ptr_d;
  logic [11:0]   clr_color_q, clr_color_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          draw_ack_q, draw_ack_d;
  logic          draw_err_q, draw_err_d;
  logic [1:0]    disp_pipe_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    clr_color_d = clr_color_q;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    draw_ack_d  = 1'b0;
    draw_err_d  = 1'b0;

    // Start/finish bookkeeping runs regardless of who owns the port this cycle.
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          clr_color_d = clr_color;
          clr_ptr_d   = '0;
          clr_busy_d  = 1'b1;
          state_d     = ST_CLEAR;
        end
      end
      ST_DONE: begin
        clr_done_d = 1'b1;
        clr_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_CLEAR: ;
      default: state_d = ST_IDLE;
    endcase

    if (disp_en) begin
      mem_addr_d = disp_addr;
    end else if (state_q == ST_CLEAR) begin
      mem_addr_d  = clr_ptr_q;
      mem_wdata_d = clr_color_q;
      mem_we_d    = 1'b1;
      clr_ptr_d   = clr_ptr_q + DW'(1);
      if (clr_ptr_q == LAST_ADDR) state_d = ST_DONE;
    end else if (draw_req && !draw_ack_q) begin
      // Gating on draw_ack_q keeps a still-held request from writing twice.
      mem_addr_d  = draw_addr;
      mem_wdata_d = draw_data;
      draw_ack_d  = 1'b1;
      if ({1'b0, draw_addr} < PIX_N_EXT) mem_we_d = 1'b1;
      else draw_err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      clr_ptr_q   <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      draw_ack_q  <= 1'b0;
      draw_err_q  <= 1'b0;
      disp_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      clr_color_q <= clr_color_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      draw_ack_q  <= draw_ack_d;
      draw_err_q  <= draw_err_d;
      disp_pipe_q <= {disp_pipe_q[0], disp_en};
    end
  end

  assign disp_data  = mem_rdata;
  assign disp_valid = disp_pipe_q[1];
  assign draw_ack   = draw_ack_q;
  assign draw_err   = draw_err_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_vram_arbiter.sv
`default_nettype none
// tb_canvas_vram_arbiter: directed bench with a 1-cycle-latency RAM model.
// Rev 1.0 - initial release
module tb_canvas_vram_arbiter;

  localparam int DW    = 15;
  localparam int PIX_N = 30000;

  logic          pclk = 1'b0;
  logic          rstn;
  logic          disp_en;
  logic [DW-1:0] disp_addr;
  logic [11:0]   disp_data;
  logic          disp_valid;
  logic          draw_req;
  logic [DW-1:0] draw_addr;
  logic [11:0]   draw_data;
  logic          draw_ack;
  logic          draw_err;
  logic          clr_start;
  logic [11:0]   clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic [DW-1:0] mem_addr;
  logic [11:0]   mem_wdata;
  logic          mem_we;
  logic [11:0]   mem_rdata;

  canvas_vram_arbiter dut (
    .pclk(pclk), .rstn(rstn),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data),
    .draw_ack(draw_ack), .draw_err(draw_err),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 pclk = ~pclk;

  logic [11:0] ram [0:32767];
  always @(posedge pclk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  int nchecks = 0;
  int nerr    = 0;

  // Monitor statistics
  logic mon_on = 1'b0;
  bit   seen [0:32767];
  int   we_cnt = 0, done_cnt = 0;
  int   clr_wr = 0, clr_dup = 0, clr_oor = 0;
  int   oth_wr = 0, ack_cnt = 0, ack_busy = 0, ack_early = 0;
  logic [DW-1:0] oth_addr;
  logic [11:0]   oth_data;

  always @(negedge pclk) begin
    if (clr_done === 1'b1) done_cnt++;
    if (mem_we === 1'b1) we_cnt++;
    if (mon_on) begin
      if (mem_we === 1'b1) begin
        if (mem_wdata == 12'h123) begin
          clr_wr++;
          if (mem_addr >= DW'(PIX_N)) clr_oor++;
          else if (seen[mem_addr]) clr_dup++;
          else seen[mem_addr] = 1'b1;
        end else begin
          oth_wr++;
          oth_addr = mem_addr;
          oth_data = mem_wdata;
        end
      end
      if (draw_ack === 1'b1) begin
        ack_cnt++;
        if (clr_busy === 1'b1) ack_busy++;
        if (done_cnt == 0) ack_early++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int we_base;
    for (int i = 0; i < 32768; i++) ram[i] = 12'(i * 3);
    rstn = 1'b0; disp_en = 1'b0; disp_addr = '0; draw_req = 1'b0; draw_addr = '0;
    draw_data = '0; clr_start = 1'b0; clr_color = '0;
    repeat (3) tick();
    rstn = 1'b1;

    // Reset state
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_ack_err", {draw_ack, draw_err}, 0);
    check("rst_clr", {clr_busy, clr_done}, 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    repeat (5) tick();
    check("idle_no_we", we_cnt, 0);

    // Display reads of 0,1,2
    disp_en = 1'b1; disp_addr = 15'd0;
    tick(); disp_addr = 15'd1;
    check("disp_addr0", 32'(mem_addr), 0);
    check("disp_valid_lat1", 32'(disp_valid), 0);
    tick(); disp_addr = 15'd2;
    check("disp_valid0", 32'(disp_valid), 1);
    check("disp_data0", 32'(disp_data), 32'h000);
    tick(); disp_en = 1'b0;
    check("disp_data1", 32'(disp_data), 32'h003);
    tick();
    check("disp_data2", 32'(disp_data), 32'h006);
    check("disp_valid2", 32'(disp_valid), 1);
    tick();
    check("disp_valid_off", 32'(disp_valid), 0);
    check("disp_no_we", we_cnt, 0);

    // Draw handshake: two writes, acks two cycles apart
    draw_req = 1'b1; draw_addr = 15'd100; draw_data = 12'hF0F;
    tick();
    check("draw1_ack", {draw_ack, draw_err}, 32'b10);
    check("draw1_we", 32'(mem_we), 1);
    check("draw1_addr", 32'(mem_addr), 100);
    check("draw1_data", 32'(mem_wdata), 32'hF0F);
    draw_addr = 15'd101; draw_data = 12'h0F0;
    tick();
    check("draw_gap_ack", 32'(draw_ack), 0);
    check("draw_gap_we", 32'(mem_we), 0);
    tick();
    check("draw2_ack", {draw_ack, draw_err}, 32'b10);
    check("draw2_addr", 32'(mem_addr), 101);
    check("draw2_data", 32'(mem_wdata), 32'h0F0);
    draw_req = 1'b0;
    tick();
    check("draw_end_ack", 32'(draw_ack), 0);
    check("draw_we_count", we_cnt, 2);
    disp_en = 1'b1; disp_addr = 15'd100;
    tick(); disp_addr = 15'd101;
    tick(); disp_en = 1'b0;
    check("readback100", 32'(disp_data), 32'hF0F);
    tick();
    check("readback101", 32'(disp_data), 32'h0F0);
    repeat (3) tick();

    // Display blocks a pending draw for 10 cycles
    disp_en = 1'b1; disp_addr = 15'd0;
    draw_req = 1'b1; draw_addr = 15'd200; draw_data = 12'hABC;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("prio_no_ack", 32'(draw_ack), 0);
      check("prio_no_we", 32'(mem_we), 0);
      check("prio_addr", 32'(mem_addr), i);
      if (i >= 1) check("prio_stream", {disp_valid, disp_data}, {1'b1, 12'((i - 1) * 3)});
      disp_addr = 15'(i + 1);
      if (i == 9) disp_en = 1'b0;
    end
    tick();
    check("prio_ack_after", 32'(draw_ack), 1);
    check("prio_grant", {mem_we, mem_addr}, {1'b1, 15'd200});
    check("prio_stream_end", {disp_valid, disp_data}, {1'b1, 12'd27});
    draw_req = 1'b0;
    tick();
    check("prio_ack_pulse", 32'(draw_ack), 0);

    // Full clear with display toggling, ignored restart and a starved draw
    mon_on = 1'b1;
    clr_color = 12'h123; clr_start = 1'b1; disp_en = 1'b1;
    tick(); clr_start = 1'b0;
    check("clr_busy_set", 32'(clr_busy), 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 70000) begin
      disp_en   = cyc[0];
      disp_addr = 15'(cyc % PIX_N);
      if (cyc == 1000) begin clr_start = 1'b1; clr_color = 12'hFFF; end
      if (cyc == 1001) begin clr_start = 1'b0; clr_color = 12'h123; end
      if (cyc == 2000) begin draw_req = 1'b1; draw_addr = 15'd300; draw_data = 12'h555; end
      tick();
      if (draw_ack) draw_req = 1'b0;
      cyc++;
    end
    check("clr_finished_in_budget", 32'(done_cnt > 0), 1);
    disp_en = 1'b0;
    for (int k = 0; k < 10 && ack_cnt == 0; k++) begin
      tick();
      if (draw_ack) draw_req = 1'b0;
    end
    tick();
    draw_req = 1'b0;
    mon_on = 1'b0;
    check("clr_write_count", clr_wr, PIX_N);
    check("clr_dup", clr_dup, 0);
    check("clr_out_of_range", clr_oor, 0);
    check("clr_done_pulses", done_cnt, 1);
    check("clr_busy_cleared", 32'(clr_busy), 0);
    check("clr_draw_acks", ack_cnt, 1);
    check("clr_ack_while_busy", ack_busy, 0);
    check("clr_ack_before_done", ack_early, 0);
    check("clr_draw_write", {oth_wr[3:0], oth_addr, oth_data}, {4'd1, 15'd300, 12'h555});

    // Out-of-range draw
    we_base = we_cnt;
    draw_req = 1'b1; draw_addr = 15'd30000; draw_data = 12'h777;
    tick();
    check("err_ack_err", {draw_ack, draw_err}, 32'b11);
    check("err_no_we", 32'(mem_we), 0);
    draw_req = 1'b0;
    tick();
    check("err_pulse", {draw_ack, draw_err}, 0);
    check("err_we_count", we_cnt - we_base, 0);

    // Reset mid-clear, then restart from address 0
    clr_color = 12'h456; clr_start = 1'b1;
    tick(); clr_start = 1'b0;
    repeat (500) tick();
    check("mid_clr_busy", 32'(clr_busy), 1);
    rstn = 1'b0;
    tick();
    check("rst_mid_clr", {clr_busy, clr_done, mem_we}, 0);
    rstn = 1'b1;
    repeat (5) tick();
    check("rst_no_done", done_cnt, 1);
    check("rst_idle_we", 32'(mem_we), 0);
    clr_color = 12'h789; clr_start = 1'b1;
    tick(); clr_start = 1'b0;
    check("restart_busy", {clr_busy, mem_we}, 32'b10);
    tick();
    check("restart_first", {mem_we, mem_addr, mem_wdata}, {1'b1, 15'd0, 12'h789});
    tick();
    check("restart_second", {mem_we, mem_addr}, {1'b1, 15'd1});
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
